vx_mem_rsp_tag_demux: RTL and testbench

//  Response-side counterpart of the memory request arbiters that widen tags with
//  ARB_SEL_BITS select bits (I/D-cache, L2, L3 memory ports). Accepts one memory

---
 rtl/vx_mem_rsp_tag_demux.sv | 116 +++++++++++
 tb/tb_vx_mem_rsp_tag_demux.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_rsp_tag_demux.sv
// Routes one memory response stream to NUM_OUTPUTS requester ports by the tag's
// low select bits, stripping them, with a 2-entry FIFO in front of each port.
module vx_mem_rsp_tag_demux #(
  parameter  int NUM_OUTPUTS  = 4,
  parameter  int DATA_WIDTH   = 512,
  parameter  int TAG_WIDTH    = 8,
  localparam int SEL_BITS     = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 0,
  localparam int IN_TAG_WIDTH = TAG_WIDTH + SEL_BITS
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic [IN_TAG_WIDTH-1:0]           in_tag,
  output logic                              in_ready,
  output logic [NUM_OUTPUTS-1:0]            out_valid,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUTPUTS*TAG_WIDTH-1:0]  out_tag,
  input  logic [NUM_OUTPUTS-1:0]            out_ready,
  output logic                              sel_err
);

  // Handshake: a beat transfers on any edge where valid & ready are both high.
  // in_ready depends only on in_tag and out_ready, so a producer may hold
  // in_valid low while probing readiness; valid, once high, stays until taken.

  localparam int SEL_W = (SEL_BITS > 0) ? SEL_BITS : 1;

  logic [SEL_W-1:0]      w_sel;
  logic [TAG_WIDTH-1:0]  w_tag;
  logic                  w_sel_ok;
  logic [NUM_OUTPUTS-1:0] w_full;
  logic [NUM_OUTPUTS-1:0] w_pop;
  logic [NUM_OUTPUTS-1:0] w_push;

  logic [DATA_WIDTH-1:0] r_mem_data [NUM_OUTPUTS][2];
  logic [TAG_WIDTH-1:0]  r_mem_tag  [NUM_OUTPUTS][2];
  logic [1:0]            r_count    [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] r_head;
  logic [NUM_OUTPUTS-1:0] r_tail;
  logic                  r_sel_err;

  generate
    if (SEL_BITS == 0) begin : g_nosel
      assign w_sel = '0;
      assign w_tag = in_tag;
    end else begin : g_sel
      assign w_sel = in_tag[SEL_BITS-1:0];
      assign w_tag = in_tag[IN_TAG_WIDTH-1:SEL_BITS];
    end

    // Only a non-power-of-two port count leaves select codes without a port.
    if ((1 << SEL_BITS) == NUM_OUTPUTS) begin : g_sel_full
      assign w_sel_ok = 1'b1;
    end else begin : g_sel_part
      assign w_sel_ok = (w_sel < SEL_W'(NUM_OUTPUTS));
    end

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_port
      assign out_valid[g] = (r_count[g] != 2'd0);
      assign w_full[g]    = (r_count[g] == 2'd2);
      assign w_pop[g]     = out_valid[g] & out_ready[g];
      assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = r_mem_data[g][r_head[g]];
      assign out_tag[g*TAG_WIDTH +: TAG_WIDTH]    = r_mem_tag[g][r_head[g]];
    end
  endgenerate

  // A full port still accepts when it pops this cycle; unmatched selects are
  // always accepted and dropped.
  always_comb begin
    in_ready = 1'b1;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (w_sel == SEL_W'(i) && w_full[i] && !w_pop[i]) in_ready = 1'b0;
    end
  end

  always_comb begin
    w_push = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (in_valid && in_ready && w_sel == SEL_W'(i)) w_push[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_sel_err <= 1'b0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        r_count[i] <= 2'd0;
        for (int j = 0; j < 2; j++) begin
          r_mem_data[i][j] <= '0;
          r_mem_tag[i][j]  <= '0;
        end
      end
    end else begin
      r_sel_err <= r_sel_err | (in_valid & ~w_sel_ok);
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        if (w_push[i]) begin
          r_mem_data[i][r_tail[i]] <= in_data;
          r_mem_tag[i][r_tail[i]]  <= w_tag;
          r_tail[i]                <= ~r_tail[i];
        end
        if (w_pop[i]) r_head[i] <= ~r_head[i];
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + 2'd1;
          2'b01:   r_count[i] <= r_count[i] - 2'd1;
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  assign sel_err = r_sel_err;

endmodule

// File: tb/tb_vx_mem_rsp_tag_demux.sv
// Randomized and directed checks of the response tag demux against per-port
// queue models; a second 3-port instance covers out-of-range selects.
module tb_vx_mem_rsp_tag_demux;

  localparam int NO = 4;
  localparam int DW = 512;
  localparam int TW = 8;
  localparam int ITW = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic [ITW-1:0]    in_tag = '0;
  logic              in_ready;
  logic [NO-1:0]     out_valid;
  logic [NO*DW-1:0]  out_data;
  logic [NO*TW-1:0]  out_tag;
  logic [NO-1:0]     out_ready = '0;
  logic              sel_err;

  logic              in3_valid = 1'b0;
  logic [31:0]       in3_data = '0;
  logic [ITW-1:0]    in3_tag = '0;
  logic              in3_ready;
  logic [2:0]        out3_valid;
  logic [95:0]       out3_data;
  logic [23:0]       out3_tag;
  logic [2:0]        out3_ready = '0;
  logic              sel_err3;

  int n_checks = 0;
  int n_errors = 0;

  // Per-port expected responses, entry = {tag, data}, oldest first.
  logic [TW+DW-1:0] exp_q [NO][$];

  vx_mem_rsp_tag_demux #(.NUM_OUTPUTS(NO), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_tag(in_tag), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_tag(out_tag), .out_ready(out_ready), .sel_err(sel_err)
  );

  vx_mem_rsp_tag_demux #(.NUM_OUTPUTS(3), .DATA_WIDTH(32), .TAG_WIDTH(TW)) dut3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in3_valid), .in_data(in3_data),
    .in_tag(in3_tag), .in_ready(in3_ready), .out_valid(out3_valid),
    .out_data(out3_data), .out_tag(out3_tag), .out_ready(out3_ready), .sel_err(sel_err3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock of traffic on the 4-port instance: drive, compare, advance model.
  task automatic step4(input logic v, input logic [ITW-1:0] tag, input logic [DW-1:0] d,
                       input logic [NO-1:0] ordy, output logic rdy_obs);
    int sel;
    logic exp_rdy;
    logic [NO-1:0] exp_v;
    logic [TW+DW-1:0] e;
    @(negedge clk);
    in_valid = v;
    in_tag = tag;
    in_data = d;
    out_ready = ordy;
    #1;
    sel = int'(tag[1:0]);
    exp_rdy = !(exp_q[sel].size() == 2 && !ordy[sel]);
    check("in_ready", DW'(in_ready), DW'(exp_rdy));
    for (int i = 0; i < NO; i++) exp_v[i] = (exp_q[i].size() != 0);
    check("out_valid", DW'(out_valid), DW'(exp_v));
    for (int i = 0; i < NO; i++) begin
      if (exp_v[i]) begin
        e = exp_q[i][0];
        check("out_data", out_data[i*DW +: DW], e[DW-1:0]);
        check("out_tag", DW'(out_tag[i*TW +: TW]), DW'(e[TW+DW-1:DW]));
      end
    end
    for (int i = 0; i < NO; i++) begin
      if (exp_v[i] && ordy[i]) void'(exp_q[i].pop_front());
    end
    if (v && exp_rdy) exp_q[sel].push_back({tag[ITW-1:2], d});
    rdy_obs = in_ready;
  endtask

  task automatic drain4();
    logic r;
    for (int k = 0; k < 4; k++) step4(1'b0, '0, '0, 4'hF, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    in_tag = '0;
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_sel_err", DW'(sel_err), '0);
    check("rst_in_ready", DW'(in_ready), DW'(1'b1));
    for (int i = 0; i < NO; i++) begin
      check("rst_out_data", out_data[i*DW +: DW], '0);
      check("rst_out_tag", DW'(out_tag[i*TW +: TW]), '0);
      exp_q[i].delete();
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic r;
    logic [DW-1:0] d;
    logic [NO-1:0] ordy;
    logic [ITW-1:0] tg;

    repeat (2) @(negedge clk);
    do_reset();

    // Random traffic, then a reset in the middle of it.
    for (int c = 0; c < 60; c++)
      step4($urandom_range(0, 3) != 0, ITW'($urandom), rnd_data(), NO'($urandom), r);
    do_reset();

    // Routing: sel 3, tag 0xA8.
    d = {64{8'h55}};
    step4(1'b1, 10'h2A3, d, 4'h0, r);
    step4(1'b0, '0, '0, 4'h0, r);
    check("t2_valid", DW'(out_valid), DW'(4'b1000));
    check("t2_tag", DW'(out_tag[3*TW +: TW]), DW'(8'hA8));
    check("t2_data", out_data[3*DW +: DW], d);
    drain4();

    // Backpressure on port 1.
    step4(1'b1, {8'h01, 2'd1}, rnd_data(), 4'h0, r);
    check("t3_acc1", DW'(r), DW'(1'b1));
    step4(1'b1, {8'h02, 2'd1}, rnd_data(), 4'h0, r);
    check("t3_acc2", DW'(r), DW'(1'b1));
    d = rnd_data();
    step4(1'b1, {8'h03, 2'd1}, d, 4'h0, r);
    check("t3_stall", DW'(r), DW'(1'b0));
    step4(1'b1, {8'h03, 2'd1}, d, 4'b0010, r);
    check("t3_acc3", DW'(r), DW'(1'b1));
    drain4();

    // Full port 0 popped and pushed in the same cycle.
    step4(1'b1, {8'h10, 2'd0}, rnd_data(), 4'h0, r);
    step4(1'b1, {8'h11, 2'd0}, rnd_data(), 4'h0, r);
    step4(1'b1, {8'h12, 2'd0}, rnd_data(), 4'b0001, r);
    check("t4_acc", DW'(r), DW'(1'b1));
    step4(1'b0, '0, '0, 4'h0, r);
    check("t4_valid0", DW'(out_valid[0]), DW'(1'b1));
    drain4();

    // Port 2 stalled full must not block port 0.
    step4(1'b1, {8'h20, 2'd2}, rnd_data(), 4'h0, r);
    step4(1'b1, {8'h21, 2'd2}, rnd_data(), 4'h0, r);
    for (int k = 0; k < 4; k++) begin
      step4(1'b1, {8'(8'h30 + k), 2'd0}, rnd_data(), 4'b0001, r);
      check("t5_iso", DW'(r), DW'(1'b1));
    end
    drain4();

    // Random traffic with random backpressure.
    for (int c = 0; c < 500; c++) begin
      ordy = NO'($urandom) | NO'($urandom);
      step4($urandom_range(0, 3) != 0, ITW'($urandom), rnd_data(), ordy, r);
    end
    drain4();

    // Sustained full rate with consumers always ready.
    for (int c = 0; c < 40; c++) begin
      tg = ITW'($urandom);
      step4(1'b1, tg, rnd_data(), 4'hF, r);
      check("thru_ready", DW'(r), DW'(1'b1));
    end
    drain4();

    // Three-port instance: select 3 has no port.
    @(negedge clk);
    in3_valid = 1'b1;
    in3_tag = {8'h5C, 2'd3};
    in3_data = 32'hDEAD_BEEF;
    out3_ready = 3'b000;
    #1;
    check("t6_ready", DW'(in3_ready), DW'(1'b1));
    check("t6_err_pre", DW'(sel_err3), '0);
    @(negedge clk);
    in3_valid = 1'b1;
    in3_tag = {8'h11, 2'd2};
    in3_data = 32'h1234_5678;
    #1;
    check("t6_no_valid", DW'(out3_valid), '0);
    check("t6_err_set", DW'(sel_err3), DW'(1'b1));
    @(negedge clk);
    in3_valid = 1'b0;
    #1;
    check("t6_valid2", DW'(out3_valid), DW'(3'b100));
    check("t6_tag2", DW'(out3_tag[16 +: 8]), DW'(8'h11));
    check("t6_data2", DW'(out3_data[64 +: 32]), DW'(32'h1234_5678));
    check("t6_err_sticky", DW'(sel_err3), DW'(1'b1));
    check("t6_err_main", DW'(sel_err), '0);
    do_reset();
    check("t6_err_clr", DW'(sel_err3), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
